// File: rtl/digest_serializer.sv
// digest_serializer: turns one SHA-2 hash state into a byte stream, with an optional multihash header.
// The stream is sent on a W-bit AXIS output over as many beats as needed, with an exact tkeep on the last beat.
`ifndef CODEC_POS
`define CODEC_POS 0
`endif
module digest_serializer #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_M_AXIS_DATA_WIDTH  = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter bit PREPEND_MULTIHASH    = 1
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              codec_err
);
  localparam int W  = C_M_AXIS_DATA_WIDTH;
  localparam int B  = W / 8;
  localparam int LB = $clog2(B);
  localparam int SW = 536;
  typedef enum logic {IDLE, SEND} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_buf, w_buf;
  logic [6:0] r_n, r_cnt, w_n, w_len, w_d;
  logic [7:0] w_sum;
  logic [B-1:0] r_keep, w_keep;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] r_user;
  logic r_err, w_ok, w_wide, w_acc, w_last, w_unused;
  logic [15:0] w_field, w_codec;
  logic [1:0] w_hl;
  logic [23:0] w_hdr;
  logic [511:0] w_dg64, w_mask;
  logic [255:0] w_dg32;
  assign w_unused = s_axis_tlast;
  assign w_field = s_axis_tuser[`CODEC_POS +: 16];
  assign w_codec = w_field[7:0] >= 8'h80 ? {w_field[7:0], w_field[15:8]} : w_field;
  // SHA2-224 is recognised both as its numeric codec and as its varint wire bytes 0x93 0x20 after the swap
  always_comb begin
    w_ok = 1'b1;
    w_wide = 1'b1;
    w_d = 7'd64;
    w_hl = 2'd2;
    w_hdr = 24'h004013;
    if (w_codec == 16'h1013 || w_codec == 16'h9320) begin
      w_wide = 1'b0;
      w_d = 7'd28;
      w_hl = 2'd3;
      w_hdr = 24'h1C2093;
    end else if (w_codec == 16'h0012) begin
      w_wide = 1'b0;
      w_d = 7'd32;
      w_hdr = 24'h002012;
    end else if (w_codec == 16'h0020) begin
      w_d = 7'd48;
      w_hdr = 24'h003020;
    end else if (w_codec != 16'h0013) w_ok = 1'b0;
    if (!PREPEND_MULTIHASH) begin
      w_hl = 2'd0;
      w_hdr = 24'h0;
    end
  end
  always_comb begin
    w_dg64 = '0;
    w_dg32 = '0;
    for (int j = 0; j < 64; j++) w_dg64[8*j +: 8] = s_axis_tdata[64*(j/8) + 56 - 8*(j%8) +: 8];
    for (int j = 0; j < 32; j++) w_dg32[8*j +: 8] = s_axis_tdata[64*(j/4) + 56 - 8*(j%4) +: 8];
  end
  assign w_mask = ~({512{1'b1}} << {w_d, 3'b0});
  assign w_buf  = ({24'b0, (w_wide ? w_dg64 : {256'b0, w_dg32}) & w_mask} << {w_hl, 3'b0}) | {512'b0, w_hdr};
  assign w_len  = w_d + 7'(w_hl);
  assign w_sum  = {1'b0, w_len} + 8'(B - 1);
  assign w_n    = 7'(w_sum >> LB);
  assign w_keep = w_len[LB-1:0] == '0 ? '1 : ~({B{1'b1}} << w_len[LB-1:0]);
  assign w_acc  = r_state == IDLE && s_axis_tvalid;
  assign w_last = r_cnt == r_n - 7'd1;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_acc && w_ok ? SEND : IDLE) : (m_axis_tready && w_last ? IDLE : SEND);
  end
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state <= IDLE;
      r_buf <= '0;
      r_n <= '0;
      r_cnt <= '0;
      r_keep <= '0;
      r_user <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err <= w_acc && !w_ok;
      if (w_acc && w_ok) begin
        r_buf <= w_buf;
        r_n <= w_n;
        r_keep <= w_keep;
        r_user <= s_axis_tuser;
        r_cnt <= '0;
      end else if (r_state == SEND && m_axis_tready) begin
        r_buf <= r_buf >> W;
        r_cnt <= r_cnt + 7'd1;
      end
    end
  end
  assign s_axis_tready = r_state == IDLE;
  assign m_axis_tvalid = r_state == SEND;
  assign m_axis_tlast  = m_axis_tvalid && w_last;
  assign m_axis_tkeep  = !m_axis_tvalid ? '0 : w_last ? r_keep : '1;
  assign m_axis_tdata  = m_axis_tvalid ? r_buf[W-1:0] : '0;
  assign m_axis_tuser  = r_user;
  assign codec_err     = r_err;
endmodule

// File: tb/tb_digest_serializer.sv
// tb_digest_serializer: randomized scoreboard bench; instance 0 prepends the multihash header, instance 1 emits raw digests.
`ifndef CODEC_POS
`define CODEC_POS 0
`endif
module tb_digest_serializer;
  localparam int W = 128, B = W / 8, UW = 128;
  typedef struct packed {
    logic [W-1:0] data;
    logic [B-1:0] keep;
    logic last;
    logic [UW-1:0] user;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [511:0] s_data [2];
  logic [UW-1:0] s_user [2], m_user [2];
  logic s_valid [2], s_rdy [2], m_valid [2], m_last [2], m_rdy [2], err [2];
  logic [W-1:0] m_data [2];
  logic [B-1:0] m_keep [2];
  beat_t q [2][$];
  int total = 0, bad = 0;
  int err_exp [2] = '{0, 0}, err_seen [2] = '{0, 0}, beats_done [2] = '{0, 0};
  bit rnd_rdy = 1'b0;
  logic [31:0] abc [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  logic [15:0] cods [6] = '{16'h2093, 16'h1013, 16'h0012, 16'h0020, 16'h0013, 16'h0011};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    digest_serializer #(.PREPEND_MULTIHASH(g == 0)) u_dut (
      .axis_aclk(clk), .axis_resetn(rst_n),
      .s_axis_tdata(s_data[g]), .s_axis_tuser(s_user[g]), .s_axis_tvalid(s_valid[g]),
      .s_axis_tlast(1'b1), .s_axis_tready(s_rdy[g]),
      .m_axis_tdata(m_data[g]), .m_axis_tkeep(m_keep[g]), .m_axis_tuser(m_user[g]),
      .m_axis_tvalid(m_valid[g]), .m_axis_tready(m_rdy[g]), .m_axis_tlast(m_last[g]),
      .codec_err(err[g]));
  end

  initial forever #5 clk = ~clk;
  initial begin
    #900us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: build the byte string from the codec table, then cut it into W-bit beats.
  function automatic void model(input int d, input logic [511:0] data, input logic [UW-1:0] user, output bit ok);
    logic [15:0] f, c;
    byte unsigned s[$];
    logic [63:0] w64;
    int dl, len, nb;
    beat_t bt;
    f = user[`CODEC_POS +: 16];
    c = f[7:0] >= 8'h80 ? {f[7:0], f[15:8]} : f;
    ok = 1'b1;
    dl = 0;
    case (c)
      16'h1013, 16'h9320: begin dl = 28; s = '{8'h93, 8'h20, 8'h1C}; end
      16'h0012: begin dl = 32; s = '{8'h12, 8'h20}; end
      16'h0020: begin dl = 48; s = '{8'h20, 8'h30}; end
      16'h0013: begin dl = 64; s = '{8'h13, 8'h40}; end
      default: ok = 1'b0;
    endcase
    if (!ok) return;
    if (d == 1) s.delete();
    len = s.size() + dl;
    for (int i = 0; i < 8; i++) begin
      w64 = data[64*i +: 64];
      for (int b = 7; b >= (dl > 32 ? 0 : 4); b--) s.push_back(w64[8*b +: 8]);
    end
    while (s.size() > len) void'(s.pop_back());
    nb = (len + B - 1) / B;
    for (int n = 0; n < nb; n++) begin
      bt = '0;
      bt.user = user;
      bt.last = n == nb - 1;
      for (int k = 0; k < B; k++)
        if (n * B + k < len) begin
          bt.data[8*k +: 8] = s[n*B + k];
          bt.keep[k] = 1'b1;
        end
      q[d].push_back(bt);
    end
  endfunction

  function automatic logic [UW-1:0] mkuser(input logic [15:0] f);
    logic [UW-1:0] u;
    for (int i = 0; i < UW / 32; i++) u[32*i +: 32] = $urandom();
    u[`CODEC_POS +: 16] = f;
    return u;
  endfunction

  function automatic logic [511:0] rdata();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic send(input int d, input logic [511:0] data, input logic [UW-1:0] user);
    bit ok;
    int t = 0;
    @(negedge clk);
    s_data[d] = data;
    s_user[d] = user;
    s_valid[d] = 1'b1;
    while (!s_rdy[d] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_rdy[d]) begin
      total++;
      bad++;
      $display("FAIL accept timeout dut%0d", d);
      s_valid[d] = 1'b0;
      return;
    end
    model(d, data, user, ok);
    if (!ok) err_exp[d]++;
    @(posedge clk);
    #1 s_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t = 0;
    while ((q[d].size() != 0 || m_valid[d]) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 2000) begin
      total++;
      bad++;
      $display("FAIL drain timeout dut%0d left=%0d", d, q[d].size());
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) m_rdy[d] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every handshake and checks stability across stalls.
  initial begin
    beat_t prev [2], cur, exp;
    bit stall [2];
    stall = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cur = {m_data[d], m_keep[d], m_last[d], m_user[d]};
        if (!rst_n) stall[d] = 1'b0;
        if (err[d]) err_seen[d]++;
        if (stall[d]) chk($sformatf("stable dut%0d", d), cur, prev[d]);
        if (m_valid[d]) chk($sformatf("tready low in send dut%0d", d), s_rdy[d], 1'b0);
        if (m_valid[d] && m_rdy[d]) begin
          if (q[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected beat dut%0d data=%h", d, m_data[d]);
          end else begin
            exp = q[d].pop_front();
            chk($sformatf("tdata dut%0d", d), cur.data, exp.data);
            chk($sformatf("tkeep dut%0d", d), cur.keep, exp.keep);
            chk($sformatf("tlast dut%0d", d), cur.last, exp.last);
            chk($sformatf("tuser dut%0d", d), cur.user, exp.user);
          end
          beats_done[d]++;
        end
        stall[d] = m_valid[d] && !m_rdy[d];
        prev[d] = cur;
      end
    end
  end

  initial begin
    logic [511:0] abc_data;
    int t, base;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0;
      s_data[d] = '0;
      s_user[d] = '0;
      m_rdy[d] = 1'b1;
    end
    abc_data = rdata();
    for (int i = 0; i < 8; i++) abc_data[64*i + 32 +: 32] = abc[i];
    repeat (3) @(posedge clk);
    #1;
    chk("reset s_tready", s_rdy[0], 1'b1);
    chk("reset m_tvalid", m_valid[0], 1'b0);
    chk("reset m_tlast", m_last[0], 1'b0);
    chk("reset codec_err", err[0], 1'b0);
    chk("reset m_tdata", m_data[0], '0);
    chk("reset m_tkeep", m_keep[0], '0);
    chk("reset m_tuser", m_user[0], '0);
    chk("reset s_tready raw", s_rdy[1], 1'b1);
    @(negedge clk) rst_n = 1'b1;
    send(0, abc_data, mkuser(16'h0012));
    send(1, abc_data, mkuser(16'h0012));
    send(0, rdata(), mkuser(16'h2093));
    send(1, rdata(), mkuser(16'h2093));
    send(0, rdata(), mkuser(16'h1013));
    drain(0);
    drain(1);
    send(0, rdata(), mkuser(16'h0011));
    chk("tready after bad codec", s_rdy[0], 1'b1);
    send(0, abc_data, mkuser(16'h0012));
    drain(0);
    chk("codec_err pulse", err_seen[0], 1);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 24; i++) send(i % 2, rdata(), mkuser(cods[$urandom_range(0, 5)]));
    send(0, rdata(), mkuser(16'h0013));
    drain(0);
    drain(1);
    rnd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    base = beats_done[0];
    send(0, rdata(), mkuser(16'h0013));
    t = 0;
    while (beats_done[0] < base + 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("beats left at reset", q[0].size(), 3);
    chk("midreset m_tvalid", m_valid[0], 1'b0);
    chk("midreset m_tlast", m_last[0], 1'b0);
    chk("midreset m_tdata", m_data[0], '0);
    chk("midreset m_tkeep", m_keep[0], '0);
    chk("midreset m_tuser", m_user[0], '0);
    chk("midreset s_tready", s_rdy[0], 1'b1);
    q[0].delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no partial after reset", m_valid[0], 1'b0);
    chk("tready after reset", s_rdy[0], 1'b1);
    send(0, rdata(), mkuser(16'h0013));
    send(0, abc_data, mkuser(16'h0012));
    drain(0);
    drain(1);
    repeat (2) @(posedge clk);
    chk("codec_err count dut0", err_seen[0], err_exp[0]);
    chk("codec_err count dut1", err_seen[1], err_exp[1]);
    chk("queue empty dut0", q[0].size(), 0);
    chk("queue empty dut1", q[1].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
